// File: rtl/pc_sequencer.sv
// Program counter sequencer with a circular return-address stack.
// Handles sequential, relative branch, absolute jump, call and return.
module pc_sequencer #(
    parameter int              WIDTH     = 32,
    parameter int              STEP      = 1,
    parameter int              RAS_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    localparam int             PW        = $clog2(RAS_DEPTH),
    localparam int             CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             cond,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] link,
    output logic [CW-1:0]    ras_count,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_ovf,
    output logic             ras_unf
);

    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [WIDTH-1:0] pc_nxt;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             unf_set;

    assign link      = pc + WIDTH'(STEP);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign ras_empty = (ras_count == '0);
    assign rp        = wp - PW'(1);

    always_comb begin
        pc_nxt  = link;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (op)
            OP_BRANCH: if (cond) pc_nxt = pc + target;
            OP_JUMP:   pc_nxt = target;
            OP_CALL: begin
                pc_nxt  = target;
                push    = 1'b1;
                ovf_set = ras_full;
            end
            OP_RET: begin
                if (ras_empty) begin
                    unf_set = 1'b1;
                end else begin
                    pc_nxt = stack[rp];
                    pop    = 1'b1;
                end
            end
            default: pc_nxt = link;
        endcase
    end

    // Write pointer wraps, so a push on a full stack replaces the oldest entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc        <= RESET_VEC;
            wp        <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else if (en) begin
            pc <= pc_nxt;
            if (push) begin
                wp <= wp + PW'(1);
                if (!ras_full) ras_count <= ras_count + CW'(1);
            end else if (pop) begin
                wp        <= rp;
                ras_count <= ras_count - CW'(1);
            end
            if (ovf_set) ras_ovf <= 1'b1;
            if (unf_set) ras_unf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && en && push) stack[wp] <= link;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters.
// Expected values are hand-computed per vector.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  op;
    logic        cond;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] link;
    logic [3:0]  ras_count;
    logic        ras_full;
    logic        ras_empty;
    logic        ras_ovf;
    logic        ras_unf;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] SEQ = 3'b000;
    localparam logic [2:0] BR  = 3'b001;
    localparam logic [2:0] JMP = 3'b010;
    localparam logic [2:0] CAL = 3'b011;
    localparam logic [2:0] RET = 3'b100;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .op        (op),
        .cond      (cond),
        .target    (target),
        .pc        (pc),
        .link      (link),
        .ras_count (ras_count),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic e, input logic [2:0] o,
                        input logic c, input logic [31:0] t);
        reset  = rst;
        en     = e;
        op     = o;
        cond   = c;
        target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input int cnt,
                         input logic ov, input logic un);
        chk({tag, "_cnt"}, 32'(ras_count), 32'(cnt));
        chk({tag, "_ovf"}, 32'(ras_ovf), 32'(ov));
        chk({tag, "_unf"}, 32'(ras_unf), 32'(un));
    endtask

    logic [31:0] pushed [9];
    logic [31:0] hold_pc;

    initial begin
        reset = 1'b0; en = 1'b1; op = CAL; cond = 1'b0; target = 32'd77;
        #1;
        step(1'b0, 1'b1, CAL, 1'b0, 32'd77);
        step(1'b0, 1'b1, RET, 1'b0, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_link", link, 32'd1);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        chk("rst_full", 32'(ras_full), 32'd0);
        flags("rst", 0, 1'b0, 1'b0);

        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b1, SEQ, 1'b0, 32'd0);
            chk("seq_pc", pc, 32'(i));
        end
        chk("seq_link", link, 32'd4);
        step(1'b1, 1'b1, 3'b110, 1'b1, 32'd999);
        chk("seq_alias", pc, 32'd4);

        step(1'b1, 1'b1, JMP, 1'b1, 32'd10);
        chk("jmp10", pc, 32'd10);
        step(1'b1, 1'b1, BR, 1'b1, 32'hFFFF_FFFC);
        chk("br_taken", pc, 32'd6);
        step(1'b1, 1'b1, BR, 1'b0, 32'hFFFF_FFFC);
        chk("br_not", pc, 32'd7);
        step(1'b1, 1'b1, JMP, 1'b0, 32'hFFFF_FFFF);
        chk("jmp_max", pc, 32'hFFFF_FFFF);
        chk("link_wrap", link, 32'd0);
        step(1'b1, 1'b1, SEQ, 1'b0, 32'd0);
        chk("pc_wrap", pc, 32'd0);

        step(1'b1, 1'b1, JMP, 1'b0, 32'd5);
        step(1'b1, 1'b1, CAL, 1'b0, 32'd100);
        chk("c1_pc", pc, 32'd100);
        chk("c1_cnt", 32'(ras_count), 32'd1);
        step(1'b1, 1'b1, CAL, 1'b0, 32'd200);
        chk("c2_pc", pc, 32'd200);
        chk("c2_cnt", 32'(ras_count), 32'd2);
        step(1'b1, 1'b1, RET, 1'b0, 32'd0);
        chk("r1_pc", pc, 32'd101);
        chk("r1_cnt", 32'(ras_count), 32'd1);
        step(1'b1, 1'b1, RET, 1'b0, 32'd0);
        chk("r2_pc", pc, 32'd6);
        flags("r2", 0, 1'b0, 1'b0);

        // pc=6: first call pushes 7, call i>0 pushes 1000+16*(i-1)+1
        pushed[0] = 32'd7;
        for (int i = 1; i < 9; i++) pushed[i] = 32'(1000 + 16 * (i - 1) + 1);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, CAL, 1'b0, 32'(1000 + 16 * i));
            chk("ovc_pc", pc, 32'(1000 + 16 * i));
            if (i == 7) begin
                chk("full8", 32'(ras_full), 32'd1);
                flags("c8", 8, 1'b0, 1'b0);
            end
        end
        chk("full9", 32'(ras_full), 32'd1);
        flags("c9", 8, 1'b1, 1'b0);
        for (int i = 8; i >= 1; i--) begin
            step(1'b1, 1'b1, RET, 1'b0, 32'd0);
            chk("ovr_pc", pc, pushed[i]);
            chk("ovr_cnt", 32'(ras_count), 32'(i - 1));
        end
        chk("ovr_empty", 32'(ras_empty), 32'd1);
        step(1'b1, 1'b1, RET, 1'b0, 32'd0);
        chk("unf_pc", pc, 32'd1002);
        flags("unf", 0, 1'b1, 1'b1);

        step(1'b1, 1'b1, CAL, 1'b0, 32'd300);
        chk("hcall_pc", pc, 32'd300);
        hold_pc = pc;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, (i % 2 == 0) ? CAL : RET, 1'b1, 32'd555);
            chk("hold_pc", pc, hold_pc);
            flags("hold", 1, 1'b1, 1'b1);
        end
        step(1'b1, 1'b1, RET, 1'b0, 32'd0);
        chk("hold_ret", pc, 32'd1003);

        step(1'b1, 1'b1, CAL, 1'b0, 32'd400);
        step(1'b1, 1'b1, CAL, 1'b0, 32'd500);
        step(1'b1, 1'b1, CAL, 1'b0, 32'd600);
        chk("pre_cnt", 32'(ras_count), 32'd3);
        step(1'b0, 1'b1, CAL, 1'b0, 32'd700);
        chk("mrst_pc", pc, 32'd0);
        flags("mrst", 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, RET, 1'b0, 32'd0);
        chk("mrst_ret", pc, 32'd1);
        flags("mret", 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the address width in bits.
REQ-002 The block SHALL have parameter STEP, default 1, which sets the sequential increment per instruction.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 8, which sets the return-address stack entry count (power of two, >=2).
REQ-004 The block SHALL have parameter RESET_VEC, default 0, which sets the PC value loaded on reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-007 en  input  1  advance enable; 0 = stall, all state held.
REQ-008 op  input  3  000 SEQ, 001 BRANCH_REL, 010 JUMP_ABS, 011 CALL, 100 RET; 101-111 behave as SEQ.
REQ-009 cond  input  1  BRANCH_REL taken when 1.
REQ-010 target  input  WIDTH  signed offset (BRANCH_REL) or absolute address (JUMP_ABS, CALL).
REQ-011 pc  output  WIDTH  registered current PC.
REQ-012 link  output  WIDTH  combinational pc+STEP, modulo 2^WIDTH.
REQ-013 ras_count  output  clog2(RAS_DEPTH)+1  registered number of valid stack entries.
REQ-014 ras_full / ras_empty  output  1 each  combinational: count==RAS_DEPTH / count==0.
REQ-015 ras_ovf / ras_unf  output  1 each  sticky error flags, cleared only by reset.

Function
REQ-016 All PC arithmetic SHALL be modulo 2^WIDTH: no overflow detection, wrap from 2^WIDTH-1 to 0 silently.
REQ-017 When en=1, SEQ (and op=101-111) SHALL set pc to link.
REQ-018 When en=1, BRANCH_REL SHALL set pc to pc+target (two's complement) if cond=1, else to link.
REQ-019 When en=1, JUMP_ABS SHALL set pc to target; cond ignored.
REQ-020 CALL SHALL push link onto the stack and set pc to target in the same cycle.
REQ-021 CALL with ras_full=1 SHALL overwrite the oldest entry (circular), keep count at RAS_DEPTH, set ras_ovf, and still jump.
REQ-022 RET with count>0 SHALL pop the newest entry into pc and decrement count.
REQ-023 RET with ras_empty=1 SHALL set pc to link, leave count at 0, and set ras_unf.
REQ-024 When en=0, pc, stack contents, count and sticky flags SHALL hold regardless of op, cond or target.
REQ-025 Latency SHALL be one cycle: the new pc is visible after the rising edge that samples en=1 and op.
REQ-026 Stack order SHALL be LIFO: after N<=RAS_DEPTH CALLs, N RETs return addresses in reverse push order.
REQ-027 After overflow, RETs SHALL return the newest RAS_DEPTH addresses in LIFO order; a subsequent RET on empty follows REQ-023.

Reset
REQ-028 While reset=0 at a rising edge, pc SHALL be loaded with RESET_VEC, count cleared to 0, ras_ovf and ras_unf cleared; en and op are ignored.
REQ-029 Reset SHALL take priority over any op in the same cycle, including a CALL or RET mid-sequence; stale stack contents SHALL be unreachable afterwards.
REQ-030 No output SHALL be undefined after the first reset edge; link SHALL equal RESET_VEC+STEP.

Verification
REQ-031 Reset then 3 SEQ cycles with en=1 (defaults) -> pc 0,1,2,3; link 4.
REQ-032 At pc=10: BRANCH_REL target=-4 cond=1 -> pc=6; then cond=0 -> pc=7; JUMP_ABS target=0xFFFFFFFF then SEQ -> pc=0 (wrap).
REQ-033 At pc=5: CALL target=100, CALL target=200, RET, RET -> pc 100, 200, 101, 6; ras_count 1,2,1,0.
REQ-034 From empty, 9 CALLs then 9 RETs with RAS_DEPTH=8 -> ras_ovf=1 after the 9th CALL, ras_full=1; the first 8 RETs return the newest 8 links; the 9th RET gives pc+1 and ras_unf=1.
REQ-035 en=0 for 4 cycles with op=CALL and op=RET presented -> pc, ras_count and flags unchanged.
REQ-036 reset=0 asserted in the cycle of a CALL with count=3 -> pc=RESET_VEC, count=0, flags clear; the following RET -> pc=RESET_VEC+1 and ras_unf=1.
